// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment digit link: segment patterns
// {a,b,c,d,e,f,g} (a is the MSB) and the receiver frame states.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;

  // Nibble stored in place of a digit whose pattern is not recognised.
  localparam logic [3:0] BCD_BAD  = 4'hF;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to BCD decoder; unknown patterns
// (including the dash) map to 4'hF with valid_o low.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       valid_o
);

  always_comb begin
    bcd_o   = BCD_BAD;
    valid_o = 1'b1;
    unique case (seg_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_frame_receiver.sv
// Collects NDIG segment patterns (MSD first), converts the BCD frame to
// binary by repeated multiply-by-10, and holds the result until consumed.
module seg7_frame_receiver
  import seg7_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int BIN_W = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  input  logic                seg_valid,
  output logic                seg_ready,
  output logic [4*NDIG-1:0]   bcd_out,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int FW = 4 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  function automatic logic [BIN_W-1:0] mul10_add(input logic [BIN_W-1:0] acc,
                                                 input logic [3:0]       dig);
    logic [BIN_W-1:0] dx;
    dx = (dig > 4'd9) ? '0 : BIN_W'(dig);
    return (acc << 3) + (acc << 1) + dx;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FW-1:0]    shift_q, shift_d;
  logic [BIN_W-1:0] acc_q, acc_d;
  logic             ferr_q, ferr_d;
  logic [FW-1:0]    bcd_q, bcd_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             err_q, err_d;

  logic [3:0]       dec_bcd;
  logic             dec_ok;
  logic [3:0]       top_dig;
  logic [BIN_W-1:0] acc_nxt;

  seg7_to_bcd u_dec (
    .seg_i   (seg_in),
    .bcd_o   (dec_bcd),
    .valid_o (dec_ok)
  );

  // CONVERT rotates the frame left one nibble per step, so after NDIG steps
  // the shift register is back in its original order for bcd_out.
  assign top_dig = shift_q[FW-1 -: 4];
  assign acc_nxt = mul10_add(acc_q, top_dig);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    ferr_d    = ferr_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    err_d     = err_q;
    seg_ready = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      COLLECT: begin
        seg_ready = 1'b1;
        if (seg_valid) begin
          shift_d = (shift_q << 4) | FW'(dec_bcd);
          ferr_d  = ferr_q | ~dec_ok;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            acc_d   = '0;
            state_d = CONVERT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      CONVERT: begin
        shift_d = (shift_q << 4) | FW'(top_dig);
        acc_d   = acc_nxt;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          bcd_d   = (shift_q << 4) | FW'(top_dig);
          bin_d   = ferr_q ? '0 : acc_nxt;
          err_d   = ferr_q;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          ferr_d  = 1'b0;
          state_d = COLLECT;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      ferr_q  <= 1'b0;
      bcd_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      ferr_q  <= ferr_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign bcd_out = bcd_q;
  assign bin_out = bin_q;
  assign err     = err_q;

endmodule

// File: tb/tb_seg7_frame_receiver.sv
// Directed bench for seg7_frame_receiver: known frames, hold/handshake
// behaviour, error frames, mid-frame reset and a short randomised run.
module tb_seg7_frame_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic        seg_valid;
  logic        seg_ready;
  logic [15:0] bcd_out;
  logic [13:0] bin_out;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] segtab [10];

  always #5 clk = ~clk;

  seg7_frame_receiver #(.NDIG(4), .BIN_W(14)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .seg_valid (seg_valid),
    .seg_ready (seg_ready),
    .bcd_out   (bcd_out),
    .bin_out   (bin_out),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [6:0] s);
    int n;
    seg_in    = s;
    seg_valid = 1'b1;
    n = 0;
    while (seg_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("seg_ready_wait", {31'd0, seg_ready}, 32'd1);
    tick();
    seg_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0);
    send_digit(s3);
    send_digit(s2);
    send_digit(s1);
    send_digit(s0);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [15:0] eb,
                              input logic [13:0] ebin, input logic eerr);
    chk({tag, "_bcd"}, {16'd0, bcd_out}, {16'd0, eb});
    chk({tag, "_bin"}, {18'd0, bin_out}, {18'd0, ebin});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, eerr});
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd0);
    chk("release_ready", {31'd0, seg_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] eb;
    int          ebin;
    logic        eerr;
    logic [6:0]  s;

    segtab[0] = 7'b1111110; segtab[1] = 7'b0110000; segtab[2] = 7'b1101101;
    segtab[3] = 7'b1111001; segtab[4] = 7'b0110011; segtab[5] = 7'b1011011;
    segtab[6] = 7'b1011111; segtab[7] = 7'b1110000; segtab[8] = 7'b1111111;
    segtab[9] = 7'b1111011;

    reset     = 1'b0;
    seg_in    = 7'd0;
    seg_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bcd", {16'd0, bcd_out}, 32'd0);
    chk("rst_bin", {18'd0, bin_out}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b1;
    tick();
    chk("rst_seg_ready", {31'd0, seg_ready}, 32'd1);

    // 1984 with latency check: valid exactly NDIG edges after last accept
    send_frame(7'b0110000, 7'b1111011, 7'b1111111, 7'b0110011);
    chk("lat_conv0", {31'd0, out_valid}, 32'd0);
    chk("lat_ready0", {31'd0, seg_ready}, 32'd0);
    repeat (3) tick();
    chk("lat_conv3", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_hold", {31'd0, out_valid}, 32'd1);
    check_result("f1984", 16'h1984, 14'd1984, 1'b0);

    // HOLD with out_ready low: input attempts are ignored
    seg_in    = 7'b1011011;
    seg_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_ready", {31'd0, seg_ready}, 32'd0);
      chk("hold_bin", {18'd0, bin_out}, 32'd1984);
    end
    seg_valid = 1'b0;
    release_out();

    // frame with a dash: error, bin forced to 0
    send_frame(segtab[2], 7'b0000001, segtab[0], segtab[0]);
    wait_out();
    check_result("fdash", 16'h2F00, 14'd0, 1'b1);
    release_out();

    send_frame(segtab[0], segtab[0], segtab[0], segtab[1]);
    wait_out();
    check_result("f0001", 16'h0001, 14'd1, 1'b0);
    release_out();

    send_frame(segtab[9], segtab[9], segtab[9], segtab[9]);
    wait_out();
    check_result("f9999", 16'h9999, 14'h270F, 1'b0);
    release_out();

    send_frame(segtab[0], segtab[0], segtab[0], segtab[0]);
    wait_out();
    check_result("f0000", 16'h0000, 14'd0, 1'b0);
    release_out();

    // asynchronous reset in the middle of a frame
    send_digit(segtab[3]);
    send_digit(segtab[3]);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_bcd", {16'd0, bcd_out}, 32'd0);
    #2 reset = 1'b1;
    tick();
    send_frame(segtab[5], segtab[0], segtab[0], segtab[7]);
    wait_out();
    check_result("f5007", 16'h5007, 14'd5007, 1'b0);
    release_out();

    // randomised frames with gaps, consumer always ready
    out_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      eb   = 16'd0;
      ebin = 0;
      eerr = 1'b0;
      for (int d = 0; d < 4; d++) begin
        int v;
        repeat ($urandom_range(0, 2)) tick();
        v = $urandom_range(0, 10);
        if (v == 10) begin
          s    = ($urandom_range(0, 1) == 0) ? 7'b0000001 : 7'b0000000;
          eb   = {eb[11:0], 4'hF};
          ebin = ebin * 10;
          eerr = 1'b1;
        end else begin
          s    = segtab[v];
          eb   = {eb[11:0], 4'(v)};
          ebin = ebin * 10 + v;
        end
        send_digit(s);
      end
      wait_out();
      check_result("rnd", eb, eerr ? 14'd0 : 14'(ebin), eerr);
      tick();
      chk("rnd_hold1", {31'd0, out_valid}, 32'd0);
    end
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_frame_receiver.md
Name: seg7_frame_receiver

Overview:
- Receiving end of the 7-segment digit link: accepts a stream of segment patterns {a,b,c,d,e,f,g}, one digit per handshake.
- Decodes each pattern back to BCD and assembles NDIG digits into a frame, most significant digit first.
- Converts the frame to binary with an iterative multiply-by-10 accumulator.
- Presents BCD and binary results on a valid/ready output held until consumed. Sits between a display-side pattern source and counter/register logic.

Parameters:
- NDIG, 4, digits per frame (≥1).
- BIN_W, 14, binary result width; must hold 10^NDIG−1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- seg_in  in  7  segment pattern {a,b,c,d,e,f,g}; a is MSB.
- seg_valid  in  1  seg_in holds a pattern.
- seg_ready  out  1  block accepts a pattern this cycle.
- bcd_out  out  4*NDIG  frame digits; first-received digit in the top nibble.
- bin_out  out  BIN_W  binary value of the frame.
- err  out  1  frame contained at least one unrecognised pattern.
- out_valid  out  1  frame result available.
- out_ready  in  1  consumer takes the result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=COLLECT, digit count=0, accumulator=0, err=0.
  - bcd_out=0, bin_out=0, out_valid=0.
  - seg_ready=1 once reset deasserts.
- Decode table (exact, active-high segments): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Any other pattern, including dash 0000001, is invalid: store digit 4'hF and set sticky frame-error flag.
- States: COLLECT → CONVERT → HOLD → COLLECT.
- COLLECT:
  - seg_ready=1.
  - On seg_valid&seg_ready at posedge: shift decoded digit into the low nibble of the shift register; count++.
  - Acceptance with count==NDIG−1: count←0, accumulator←0, go to CONVERT.
- CONVERT:
  - seg_ready=0; exactly NDIG cycles, one digit per cycle, MSD first.
  - Each cycle: acc ← (acc<<3)+(acc<<1)+digit, truncated to BIN_W.
  - Invalid digits contribute 0.
  - On the last step, register bcd_out←shift register, bin_out←(frame error ? 0 : final acc), err←frame error; go to HOLD.
- HOLD:
  - out_valid=1, seg_ready=0; bcd_out/bin_out/err stable.
  - On out_ready=1 at posedge: go to COLLECT, out_valid=0 from that edge, frame-error flag cleared.
  - bcd_out/bin_out/err keep their values until the next frame completes.
- Latency: last digit accepted at edge k → out_valid=1 after edge k+NDIG.
- Boundary conditions:
  - seg_valid while seg_ready=0: ignored; source must hold its pattern.
  - out_ready while out_valid=0: ignored.
  - Gaps (seg_valid=0) during COLLECT: count holds, no timeout.
  - Reset mid-frame: partial digits discarded, counting restarts at 0.
  - out_ready held high continuously: HOLD lasts exactly 1 cycle.
  - Max frame (all 9s) must not overflow with the default BIN_W.

Decomposition:
- Shared package seg7_pkg holds:
  - localparam segment constants SEG_0..SEG_9 and SEG_DASH (same values as the display decoder table);
  - typedef enum state_t {COLLECT, CONVERT, HOLD}.
- One combinational sub-module, seg7_to_bcd (seg_in → bcd[3:0], valid), instantiated once. The FSM, shift register and accumulator stay in the top.

Test Plan:
- Reset, then send 0110000, 1111011, 1111111, 0110011 on consecutive cycles → 4 cycles after last accept: out_valid=1, bcd_out=16'h1984, bin_out=1984, err=0.
- In HOLD, keep out_ready=0 for 10 cycles while pulsing seg_valid → outputs stable, seg_ready=0, nothing accepted. Then out_ready=1 for 1 cycle → out_valid=0, seg_ready=1 next cycle.
- Send 2, 0000001 (dash), 0, 0 → err=1, bcd_out=16'h2F00, bin_out=0. The next clean frame 0,0,0,1 → err=0, bin_out=1.
- Frame 9,9,9,9 → bin_out=9999 (14'h270F). Frame 0,0,0,0 → bin_out=0, bcd_out=0.
- Accept 2 digits, pulse reset low mid-cycle (asynchronous), then send 5,0,0,7 → bcd_out=16'h5007, bin_out=5007, no residue from the aborted frame.
- Random seg_valid gaps with out_ready tied high over 20 frames → every frame matches the reference model; HOLD lasts 1 cycle each frame.
